// File: rtl/tree_pkg.sv
// Shared definitions for the decision-tree walk controller.
// Contents: node word field positions, error class label, root address of the
// 1-based heap layout, and the walk-state enumeration.
package tree_pkg;

    // Node word fields
    localparam int unsigned LEAF_BIT = 15;
    localparam int unsigned FIDX_HI  = 14;
    localparam int unsigned FIDX_LO  = 8;
    localparam int unsigned THR_HI   = 7;
    localparam int unsigned THR_LO   = 0;
    localparam int unsigned FIDX_W   = FIDX_HI - FIDX_LO + 1;

    // Class reported on a failed walk
    localparam logic [7:0] ERR_CLASS = 8'hFF;

    // Heap root; children of a are 2a and 2a+1
    localparam int unsigned ROOT_ADDR = 1;

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StEval,
        StDone
    } walk_state_e;

endpackage

// File: rtl/tree_feat_sel.sv
// Feature selector: picks one 8-bit feature out of the latched feature vector.
// Ports:
//   feat_vec  in   NUM_FEAT*8  latched feature vector, feature k = [8k+7:8k]
//   idx       in   FIDX_W      feature index taken from the node word
//   feat      out  8           selected feature (0 when idx is out of range)
//   idx_bad   out  1           idx >= NUM_FEAT
module tree_feat_sel
    import tree_pkg::*;
#(
    parameter int unsigned NUM_FEAT = 8
) (
    input  logic [NUM_FEAT*8-1:0] feat_vec,
    input  logic [FIDX_W-1:0]     idx,
    output logic [7:0]            feat,
    output logic                  idx_bad
);

    always_comb begin
        feat    = '0;
        idx_bad = (32'(idx) >= NUM_FEAT);
        for (int k = 0; k < NUM_FEAT; k++) begin
            if (idx == FIDX_W'(k)) begin
                feat = feat_vec[k*8 +: 8];
            end
        end
    end

endmodule

// File: rtl/tree_walk_ctrl.sv
// Decision-tree walk controller. Accepts a feature vector, walks a heap-ordered
// tree stored in a tree_dram (1-cycle registered read) from the root until a
// leaf, then returns the leaf class (or an error) on an output handshake.
// One walk in flight at a time.
// Optional feature macro: TREE_WALK_STATS_EN adds saturating result counters.
// Ports:
//   clk        in   1           clock
//   rst        in   1           synchronous reset, active-low
//   in_valid   in   1           feature vector valid
//   in_ready   out  1           idle, can accept a vector
//   in_feat    in   NUM_FEAT*8  feature vector
//   mem_addr   out  LEVEL       tree_dram read address
//   mem_data   in   16          tree_dram read data
//   out_valid  out  1           result valid
//   out_ready  in   1           result consumer ready
//   out_class  out  8           class label (ERR_CLASS on error)
//   out_err    out  1           walk error
//   busy       out  1           not idle
//   stat_done  out  32          completed results (TREE_WALK_STATS_EN only)
//   stat_err   out  16          completed error results (TREE_WALK_STATS_EN only)
module tree_walk_ctrl
    import tree_pkg::*;
#(
    parameter int unsigned LEVEL    = 4,
    parameter int unsigned NUM_FEAT = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [NUM_FEAT*8-1:0] in_feat,
    output logic [LEVEL-1:0]      mem_addr,
    input  logic [15:0]           mem_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [7:0]            out_class,
    output logic                  out_err,
    output logic                  busy
`ifdef TREE_WALK_STATS_EN
    ,
    output logic [31:0]           stat_done,
    output logic [15:0]           stat_err
`endif
);

    walk_state_e           state;
    logic [NUM_FEAT*8-1:0] feat_q;
    logic [7:0]            sel_feat;
    logic                  idx_bad;
    logic                  go_left;
    logic [LEVEL:0]        next_addr;
    logic                  walk_err;

    tree_feat_sel #(
        .NUM_FEAT (NUM_FEAT)
    ) u_feat_sel (
        .feat_vec (feat_q),
        .idx      (mem_data[FIDX_HI:FIDX_LO]),
        .feat     (sel_feat),
        .idx_bad  (idx_bad)
    );

    // next = 2a + (feat >= thr), one bit wider so falling off the tree shows in the MSB
    always_comb begin
        go_left   = (sel_feat < mem_data[THR_HI:THR_LO]);
        next_addr = {mem_addr, ~go_left};
        walk_err  = idx_bad || next_addr[LEVEL];
    end

    assign in_ready = (state == StIdle);
    assign busy     = (state != StIdle);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= StIdle;
            mem_addr  <= '0;
            out_valid <= 1'b0;
            out_class <= '0;
            out_err   <= 1'b0;
            feat_q    <= '0;
        end else begin
            case (state)
                StIdle: begin
                    if (in_valid) begin
                        feat_q   <= in_feat;
                        mem_addr <= LEVEL'(ROOT_ADDR);
                        state    <= StFetch;
                    end
                end
                StFetch: begin
                    state <= StEval;
                end
                StEval: begin
                    if (mem_data[LEAF_BIT]) begin
                        out_class <= mem_data[THR_HI:THR_LO];
                        out_err   <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= StDone;
                    end else if (walk_err) begin
                        out_class <= ERR_CLASS;
                        out_err   <= 1'b1;
                        out_valid <= 1'b1;
                        state     <= StDone;
                    end else begin
                        mem_addr <= next_addr[LEVEL-1:0];
                        state    <= StFetch;
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        mem_addr  <= '0;
                        state     <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

`ifdef TREE_WALK_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            stat_done <= '0;
            stat_err  <= '0;
        end else if (out_valid && out_ready) begin
            if (stat_done != '1) begin
                stat_done <= stat_done + 32'd1;
            end
            if (out_err && (stat_err != '1)) begin
                stat_err <= stat_err + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_tree_walk_ctrl.sv
// Scoreboard bench for tree_walk_ctrl with a behavioural tree_dram model.
module tb_tree_walk_ctrl;

    localparam int LEVEL    = 4;
    localparam int NUM_FEAT = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] in_feat = '0;
    logic [3:0]  mem_addr;
    logic [15:0] mem_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [7:0]  out_class;
    logic        out_err;
    logic        busy;
`ifdef TREE_WALK_STATS_EN
    logic [31:0] stat_done;
    logic [15:0] stat_err;
`endif

    tree_walk_ctrl #(
        .LEVEL    (LEVEL),
        .NUM_FEAT (NUM_FEAT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_feat   (in_feat),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_class (out_class),
        .out_err   (out_err),
        .busy      (busy)
`ifdef TREE_WALK_STATS_EN
        ,
        .stat_done (stat_done),
        .stat_err  (stat_err)
`endif
    );

    always #5 clk = ~clk;

    // tree_dram: registered read
    logic [15:0] mem [16];
    always @(posedge clk) mem_data <= mem[mem_addr];

    typedef struct {
        logic [7:0] cls;
        logic       err;
        int         lat;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   accept_cyc = 0;
    int   rise_cyc = 0;
    logic prev_ov = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Output monitor: samples at negedge, inputs change at posedge+1
    always @(negedge clk) begin
        if (!rst) begin
            prev_ov = 1'b0;
        end else begin
            if (out_valid && !prev_ov) rise_cyc = cyc;
            prev_ov = out_valid;
            if (busy && !out_valid) check_eq("addr_nonzero", 32'(mem_addr != 4'd0), 32'd1);
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check_eq("unexpected_result", 32'd0, 32'd1);
                end else begin
                    mon_e = sb.pop_front();
                    check_eq("class", 32'(out_class), 32'(mon_e.cls));
                    check_eq("err", 32'(out_err), 32'(mon_e.err));
                    check_eq("latency", 32'(rise_cyc - accept_cyc), 32'(mon_e.lat));
                end
            end
        end
    end

    // Reference walk over the bench's own memory image
    function automatic void model(input logic [63:0] f, output logic [7:0] c,
                                  output logic e, output int lat);
        int          a;
        int          idx;
        logic [15:0] w;
        logic [7:0]  fv;
        a   = 1;
        c   = 8'hFF;
        e   = 1'b1;
        lat = 0;
        for (int d = 0; d < LEVEL; d++) begin
            w   = mem[a];
            lat = 2 * d + 2;
            if (w[15]) begin
                c = w[7:0];
                e = 1'b0;
                return;
            end
            idx = int'(w[14:8]);
            if (idx >= NUM_FEAT) return;
            fv = f[idx*8 +: 8];
            a  = (fv < w[7:0]) ? 2 * a : 2 * a + 1;
            if (a >= 16) return;
        end
    endfunction

    task automatic send(input logic [63:0] f, input logic [7:0] cls, input logic err,
                        input int lat, input bit push, input bit wait_done);
        int n;
        bit got;
        if (push) sb.push_back('{cls: cls, err: err, lat: lat});
        @(posedge clk); #1;
        in_feat  = f;
        in_valid = 1'b1;
        got = 1'b0;
        n   = 0;
        while (!got && n < 20) begin
            @(negedge clk);
            if (in_ready) got = 1'b1;
            n++;
        end
        if (!got) begin
            check_eq("accept_timeout", 32'd0, 32'd1);
            in_valid = 1'b0;
            sb.delete();
            return;
        end
        accept_cyc = cyc + 1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_feat  = {$urandom, $urandom};
        if (wait_done) begin
            n = 0;
            while (sb.size() != 0 && n < 50) begin
                @(negedge clk);
                n++;
            end
            if (sb.size() != 0) begin
                check_eq("result_timeout", 32'd0, 32'd1);
                sb.delete();
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic load_tree1();
        for (int i = 0; i < 16; i++) mem[i] = 16'h0000;
        mem[1] = 16'h0240;
        mem[2] = 16'h8005;
        mem[3] = 16'h8009;
    endtask

    task automatic load_tree2();
        for (int i = 0; i < 16; i++) mem[i] = 16'h0000;
        mem[1] = 16'h0240;
        mem[2] = 16'h0120;
        mem[3] = 16'h8009;
        mem[4] = 16'h8007;
        mem[5] = 16'h8008;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] f;
        logic [7:0]  c;
        logic        e;
        int          l;
        int          n;

        for (int i = 0; i < 16; i++) mem[i] = 16'h0000;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_in_ready", 32'(in_ready), 32'd1);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_out_class", 32'(out_class), 32'd0);
        check_eq("rst_out_err", 32'(out_err), 32'd0);
        check_eq("rst_mem_addr", 32'(mem_addr), 32'd0);
        rst = 1'b1;

        // Depth-1 tree: left on feat2 < 0x40
        load_tree1();
        send(64'h0000_0000_0010_0000, 8'h05, 1'b0, 4, 1, 1);
        send(64'h0000_0000_0040_0000, 8'h09, 1'b0, 4, 1, 1);
        send(64'h0000_0000_003F_0000, 8'h05, 1'b0, 4, 1, 1);

        // Root leaf
        mem[1] = 16'h8003;
        send(64'h1234_5678_9ABC_DEF0, 8'h03, 1'b0, 2, 1, 1);

        // All-zero tree: always right, falls off after address 15
        for (int i = 0; i < 16; i++) mem[i] = 16'h0000;
        send(64'h0102_0304_0506_0708, 8'hFF, 1'b1, 8, 1, 1);

        // Feature index out of range, then the highest legal index
        mem[1] = 16'h0910;
        send(64'h0, 8'hFF, 1'b1, 2, 1, 1);
        mem[1] = 16'h0720;
        mem[2] = 16'h8011;
        mem[3] = 16'h8022;
        send(64'h2100_0000_0000_0000, 8'h22, 1'b0, 4, 1, 1);
        send(64'h1F00_0000_0000_0000, 8'h11, 1'b0, 4, 1, 1);

        // Depth-2 tree, random vectors against the reference walk
        load_tree2();
        for (int k = 0; k < 6; k++) begin
            f = {$urandom, $urandom};
            model(f, c, e, l);
            send(f, c, e, l, 1, 1);
        end

        // Backpressure in DONE
        load_tree1();
        out_ready = 1'b0;
        send(64'h0000_0000_0010_0000, 8'h05, 1'b0, 4, 1, 0);
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_eq("hold_reached_done", 32'(out_valid), 32'd1);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            in_valid = i[0];
            in_feat  = 64'h0000_0000_0050_0000;
            @(negedge clk);
            check_eq("hold_valid", 32'(out_valid), 32'd1);
            check_eq("hold_class", 32'(out_class), 32'h05);
            check_eq("hold_err", 32'(out_err), 32'd0);
            check_eq("hold_in_ready", 32'(in_ready), 32'd0);
        end
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        check_eq("release_in_ready", 32'(in_ready), 32'd1);
        check_eq("release_out_valid", 32'(out_valid), 32'd0);
        check_eq("release_busy", 32'(busy), 32'd0);
        check_eq("release_sb_empty", 32'(sb.size()), 32'd0);

        // Reset during the depth-2 fetch
        load_tree2();
        f = 64'h0000_0000_0010_1000;
        send(f, 8'h00, 1'b0, 0, 0, 0);
        repeat (4) @(posedge clk);
        #1;
        check_eq("mid_walk_addr", 32'(mem_addr), 32'd4);
        check_eq("mid_walk_busy", 32'(busy), 32'd1);
        rst = 1'b0;
        @(posedge clk); #1;
        check_eq("midrst_in_ready", 32'(in_ready), 32'd1);
        check_eq("midrst_out_valid", 32'(out_valid), 32'd0);
        check_eq("midrst_mem_addr", 32'(mem_addr), 32'd0);
        check_eq("midrst_busy", 32'(busy), 32'd0);
        rst = 1'b1;

        // Three good walks and one error after reset
        send(f, 8'h07, 1'b0, 6, 1, 1);
        send(64'h0000_0000_0010_3000, 8'h08, 1'b0, 6, 1, 1);
        send(64'h0000_0000_0050_0000, 8'h09, 1'b0, 4, 1, 1);
        mem[4] = 16'h0F00;
        send(f, 8'hFF, 1'b1, 6, 1, 1);
`ifdef TREE_WALK_STATS_EN
        check_eq("stat_done", stat_done, 32'd4);
        check_eq("stat_err", 32'(stat_err), 32'd1);
`endif
        check_eq("final_sb_empty", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
